// File: rtl/coproc_sequencer.sv
// Command sequencer for the UART vector coprocessor: decodes opcode bytes, streams
// operand vectors into A/B memory, and hands compute results to the transmitter.
module coproc_sequencer #(
    parameter int NUM_BYTES      = 1024,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_ready,
    input  logic                         op_finished,
    output logic [7:0]                   op,
    output logic                         calc_finished,
    output logic                         mem_we_a,
    output logic                         mem_we_b,
    output logic [$clog2(NUM_BYTES)-1:0] mem_addr,
    output logic [7:0]                   mem_wdata,
    output logic                         busy,
    output logic                         err
);

    localparam int AW = $clog2(NUM_BYTES);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_SEND} state_t;

    state_t          r_state, w_state;
    logic [AW:0]     r_cnt,   w_cnt;
    logic [TW-1:0]   r_tmo,   w_tmo;
    logic [SW-1:0]   r_set,   w_set;
    logic            r_tgt_b, w_tgt_b;
    logic [7:0]      r_op,    w_op;
    logic            r_calc,  w_calc;
    logic            r_we_a,  w_we_a;
    logic            r_we_b,  w_we_b;
    logic [AW-1:0]   r_addr,  w_addr;
    logic [7:0]      r_wdata, w_wdata;
    logic            r_busy,  w_busy;
    logic            r_err,   w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_set   <= '0;
            r_tgt_b <= 1'b0;
            r_op    <= 8'h00;
            r_calc  <= 1'b0;
            r_we_a  <= 1'b0;
            r_we_b  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 8'h00;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_tmo   <= w_tmo;
            r_set   <= w_set;
            r_tgt_b <= w_tgt_b;
            r_op    <= w_op;
            r_calc  <= w_calc;
            r_we_a  <= w_we_a;
            r_we_b  <= w_we_b;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_busy  <= w_busy;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_tmo   = r_tmo;
        w_set   = r_set;
        w_tgt_b = r_tgt_b;
        w_op    = r_op;
        w_we_a  = 1'b0;
        w_we_b  = 1'b0;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (rx_ready) begin
                    case (rx_data)
                        8'h00: ;
                        8'h01, 8'h02: begin
                            w_state = S_LOAD;
                            w_cnt   = '0;
                            w_tmo   = '0;
                            w_tgt_b = (rx_data == 8'h02);
                        end
                        8'h03, 8'h04, 8'h05: begin
                            w_op    = rx_data;
                            w_state = S_SETTLE;
                            w_set   = '0;
                        end
                        default: w_err = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                // A byte arriving on the threshold cycle wins over the timeout.
                if (rx_ready) begin
                    w_we_a  = ~r_tgt_b;
                    w_we_b  = r_tgt_b;
                    w_addr  = r_cnt[AW-1:0];
                    w_wdata = rx_data;
                    w_cnt   = r_cnt + (AW+1)'(1);
                    w_tmo   = '0;
                    if (r_cnt == (AW+1)'(NUM_BYTES - 1))
                        w_state = S_IDLE;
                end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state = S_IDLE;
                    w_err   = 1'b1;
                end else begin
                    w_tmo = r_tmo + TW'(1);
                end
            end
            S_SETTLE: begin
                if (rx_ready)
                    w_err = 1'b1;
                if (r_set == SW'(SETTLE_CYCLES - 1))
                    w_state = S_SEND;
                else
                    w_set = r_set + SW'(1);
            end
            S_SEND: begin
                if (rx_ready)
                    w_err = 1'b1;
                if (op_finished) begin
                    w_state = S_IDLE;
                    w_op    = 8'h00;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        w_calc = (w_state == S_SEND);
        w_busy = (w_state != S_IDLE);
    end

    assign op            = r_op;
    assign calc_finished = r_calc;
    assign mem_we_a      = r_we_a;
    assign mem_we_b      = r_we_b;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign busy          = r_busy;
    assign err           = r_err;

endmodule
